uart_rx_fsm: RTL

Frame-sequencing controller for the UART receiver. Detects the start edge on the synchronised serial line and drives the edge/bit counter, data sampler, deserializer and parity checker through each frame: start, data, optional parity, stop. Performs the start-glitch and stop-bit checks itself and flags completed frames. Sits in the UART_RX top between the line synchroniser and the datapath sub-blocks.

---
 rtl/uart_rx_pkg.sv | 26 ++
 rtl/uart_rx_fsm_if.sv | 39 +++
 rtl/uart_rx_fsm.sv | 132 +++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame sequencer.
//   rx_state_e     : frame sequencer states
//   SMP_OFFSET     : sample-ready edge sits at prescale/2 + SMP_OFFSET
//   PRESCALE_*     : legal oversampling ratios
//   DATA_WIDTH_DEF : default data bits per frame
package uart_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned SMP_OFFSET     = 2;
  localparam int unsigned PRESCALE_8     = 8;
  localparam int unsigned PRESCALE_16    = 16;
  localparam int unsigned PRESCALE_32    = 32;
  localparam int unsigned DATA_WIDTH_DEF = 8;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Control bundle between the frame sequencer and the receiver datapath.
//   master : the frame sequencer (consumes line/counter/sampler status, drives enables and flags)
//   slave  : the datapath / environment side
// Inputs to the sequencer: rx_in, par_en, prescale, edge_count, bit_count, sampled_bit, par_err.
// Outputs: counter_enable, data_samp_en, deser_en, par_chk_en, data_valid, par_error,
// stp_error, busy.
interface uart_rx_fsm_if #(
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
);
  logic                  rx_in;
  logic                  par_en;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BIT_CNT_W-1:0]  bit_count;
  logic                  sampled_bit;
  logic                  par_err;

  logic                  counter_enable;
  logic                  data_samp_en;
  logic                  deser_en;
  logic                  par_chk_en;
  logic                  data_valid;
  logic                  par_error;
  logic                  stp_error;
  logic                  busy;

  modport master (
    input  rx_in, par_en, prescale, edge_count, bit_count, sampled_bit, par_err,
    output counter_enable, data_samp_en, deser_en, par_chk_en, data_valid, par_error,
           stp_error, busy
  );

  modport slave (
    output rx_in, par_en, prescale, edge_count, bit_count, sampled_bit, par_err,
    input  counter_enable, data_samp_en, deser_en, par_chk_en, data_valid, par_error,
           stp_error, busy
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer. Detects the start edge, steps through start, data,
// optional parity and stop bits, checks start glitches and the stop bit, and flags frames.
// Ports:
//   clk : oversampling clock
//   rst : asynchronous active-high reset
//   bus : uart_rx_fsm_if.master control bundle (see interface header)
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned BIT_CNT_W  = 4
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fsm_if.master bus
);

  rx_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  par_en_q, par_en_d;
  logic                  glitch_q, glitch_d;
  logic                  stop_bad_q, stop_bad_d;
  logic                  par_bad_q, par_bad_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_error_q, par_error_d;
  logic                  stp_error_q, stp_error_d;

  logic [PRESCALE_W-1:0] smp_edge, smp1_edge, end_edge;
  logic                  at_smp, at_smp1, at_end, last_data;

  // Edge markers derive from the prescale latched at frame start, so mid-frame
  // changes on the input cannot disturb a frame in progress.
  assign smp_edge  = (p_q >> 1) + PRESCALE_W'(SMP_OFFSET);
  assign smp1_edge = smp_edge + PRESCALE_W'(1);
  assign end_edge  = p_q - PRESCALE_W'(1);
  assign at_smp    = (bus.edge_count == smp_edge);
  assign at_smp1   = (bus.edge_count == smp1_edge);
  assign at_end    = (bus.edge_count == end_edge);
  assign last_data = (bus.bit_count == BIT_CNT_W'(DATA_WIDTH));

  always_comb begin
    state_d      = state_q;
    p_d          = p_q;
    par_en_d     = par_en_q;
    glitch_d     = glitch_q;
    stop_bad_d   = stop_bad_q;
    par_bad_d    = par_bad_q;
    data_valid_d = 1'b0;
    par_error_d  = par_error_q;
    stp_error_d  = stp_error_q;
    bus.deser_en   = 1'b0;
    bus.par_chk_en = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!bus.rx_in) begin
          state_d    = StStart;
          p_d        = bus.prescale;
          par_en_d   = bus.par_en;
          glitch_d   = 1'b0;
          stop_bad_d = 1'b0;
          par_bad_d  = 1'b0;
        end
      end
      StStart: begin
        if (at_smp) glitch_d = bus.sampled_bit;
        // A high mid-start sample means the falling edge was noise: drop the frame quietly.
        if (at_end) state_d = glitch_q ? StIdle : StData;
      end
      StData: begin
        bus.deser_en = at_smp;
        if (at_end && last_data) state_d = par_en_q ? StParity : StStop;
      end
      StParity: begin
        bus.par_chk_en = at_smp;
        // Checker result lands one cycle after its capture pulse.
        if (at_smp1) par_bad_d = bus.par_err;
        if (at_end) state_d = StStop;
      end
      StStop: begin
        if (at_smp) stop_bad_d = ~bus.sampled_bit;
        if (at_end) begin
          state_d      = StIdle;
          data_valid_d = ~stop_bad_q & ~par_bad_q;
          par_error_d  = par_bad_q;
          stp_error_d  = stop_bad_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      p_q          <= '0;
      par_en_q     <= 1'b0;
      glitch_q     <= 1'b0;
      stop_bad_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_error_q  <= 1'b0;
      stp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      p_q          <= p_d;
      par_en_q     <= par_en_d;
      glitch_q     <= glitch_d;
      stop_bad_q   <= stop_bad_d;
      par_bad_q    <= par_bad_d;
      data_valid_q <= data_valid_d;
      par_error_q  <= par_error_d;
      stp_error_q  <= stp_error_d;
    end
  end

  // Only 8/16/32 give sensible edge markers; catch anything else at frame start.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StIdle) && !bus.rx_in) begin
      assert (prescale_legal(32'(bus.prescale)));
    end
  end

  assign bus.busy           = (state_q != StIdle);
  assign bus.counter_enable = bus.busy;
  assign bus.data_samp_en   = bus.busy;
  assign bus.data_valid     = data_valid_q;
  assign bus.par_error      = par_error_q;
  assign bus.stp_error      = stp_error_q;

endmodule
